// File: rtl/clock_hms_counter.sv
// Time-of-day counter holding HH:MM:SS as BCD digits, advanced by a 1 s enable.
// A three-state mode FSM lets the user set hours and minutes with two button pulses.
module clock_hms_counter #(
   parameter int INIT_H = 0,
   parameter int INIT_M = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sec_en,
   input  logic       blink,
   input  logic       mode_btn,
   input  logic       inc_btn,
   output logic [3:0] h10,
   output logic [3:0] h1,
   output logic [3:0] m10,
   output logic [3:0] m1,
   output logic [3:0] s10,
   output logic [3:0] s1,
   output logic [1:0] mode,
   output logic       blank_h,
   output logic       blank_m,
   output logic       day_tick
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2,
      BAD      = 2'd3
   } modeT;

   localparam logic [3:0] INIT_H10 = 4'(INIT_H / 10);
   localparam logic [3:0] INIT_H1  = 4'(INIT_H % 10);
   localparam logic [3:0] INIT_M10 = 4'(INIT_M / 10);
   localparam logic [3:0] INIT_M1  = 4'(INIT_M % 10);

   modeT       r_mode;
   logic [3:0] r_h10, r_h1, r_m10, r_m1, r_s10, r_s1;
   logic       r_dayTick;

   modeT       w_modeNext;
   logic [3:0] w_h10Next, w_h1Next, w_m10Next, w_m1Next, w_s10Next, w_s1Next;
   logic       w_dayTickNext;
   logic       w_doSec, w_doMinInc, w_doHourInc, w_clrSec;

   logic w_s1Wrap, w_secWrap, w_m1Wrap, w_minWrap, w_h1Wrap, w_hourWrap;

   assign w_s1Wrap   = (r_s1 == 4'd9);
   assign w_secWrap  = w_s1Wrap && (r_s10 == 4'd5);
   assign w_m1Wrap   = (r_m1 == 4'd9);
   assign w_minWrap  = w_m1Wrap && (r_m10 == 4'd5);
   assign w_h1Wrap   = (r_h1 == 4'd9);
   assign w_hourWrap = (r_h10 == 4'd2) && (r_h1 == 4'd3);

   // Mode FSM: decides which digit groups step this cycle; mode_btn always wins over inc_btn.
   always_comb begin
      w_modeNext    = r_mode;
      w_doSec       = 1'b0;
      w_doMinInc    = 1'b0;
      w_doHourInc   = 1'b0;
      w_clrSec      = 1'b0;
      w_dayTickNext = 1'b0;
      case (r_mode)
         RUN: begin
            w_doSec       = sec_en;
            w_doMinInc    = sec_en && w_secWrap;
            w_doHourInc   = sec_en && w_secWrap && w_minWrap;
            w_dayTickNext = sec_en && w_secWrap && w_minWrap && w_hourWrap;
            if (mode_btn) w_modeNext = SET_HOUR;
         end
         SET_HOUR: begin
            if (mode_btn) w_modeNext = SET_MIN;
            else          w_doHourInc = inc_btn;
         end
         SET_MIN: begin
            if (mode_btn) begin
               w_modeNext = RUN;
               w_clrSec   = 1'b1;
            end else begin
               w_doMinInc = inc_btn;
            end
         end
         default: w_modeNext = RUN;
      endcase
   end

   // Per-digit arithmetic with explicit wrap; minute wrap in set mode never reaches hours.
   always_comb begin
      w_h10Next = r_h10;
      w_h1Next  = r_h1;
      w_m10Next = r_m10;
      w_m1Next  = r_m1;
      w_s10Next = r_s10;
      w_s1Next  = r_s1;
      if (w_doSec) begin
         w_s1Next = w_s1Wrap ? 4'd0 : r_s1 + 4'd1;
         if (w_s1Wrap) w_s10Next = (r_s10 == 4'd5) ? 4'd0 : r_s10 + 4'd1;
      end
      if (w_clrSec) begin
         w_s10Next = 4'd0;
         w_s1Next  = 4'd0;
      end
      if (w_doMinInc) begin
         w_m1Next = w_m1Wrap ? 4'd0 : r_m1 + 4'd1;
         if (w_m1Wrap) w_m10Next = (r_m10 == 4'd5) ? 4'd0 : r_m10 + 4'd1;
      end
      if (w_doHourInc) begin
         if (w_hourWrap) begin
            w_h10Next = 4'd0;
            w_h1Next  = 4'd0;
         end else begin
            w_h1Next = w_h1Wrap ? 4'd0 : r_h1 + 4'd1;
            if (w_h1Wrap) w_h10Next = r_h10 + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode    <= RUN;
         r_h10     <= INIT_H10;
         r_h1      <= INIT_H1;
         r_m10     <= INIT_M10;
         r_m1      <= INIT_M1;
         r_s10     <= 4'd0;
         r_s1      <= 4'd0;
         r_dayTick <= 1'b0;
      end else begin
         r_mode    <= w_modeNext;
         r_h10     <= w_h10Next;
         r_h1      <= w_h1Next;
         r_m10     <= w_m10Next;
         r_m1      <= w_m1Next;
         r_s10     <= w_s10Next;
         r_s1      <= w_s1Next;
         r_dayTick <= w_dayTickNext;
      end
   end

   assign h10      = r_h10;
   assign h1       = r_h1;
   assign m10      = r_m10;
   assign m1       = r_m1;
   assign s10      = r_s10;
   assign s1       = r_s1;
   assign mode     = r_mode;
   assign day_tick = r_dayTick;
   assign blank_h  = (r_mode == SET_HOUR) && !blink;
   assign blank_m  = (r_mode == SET_MIN) && !blink;

endmodule

// File: tb/tb_clock_hms_counter.sv
// Bench for clock_hms_counter: seconds-of-day model checked every cycle,
// plus directed sequences with literal expected times.
module tb_clock_hms_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sec_en = 1'b0;
   logic       blink = 1'b0;
   logic       mode_btn = 1'b0;
   logic       inc_btn = 1'b0;
   logic [3:0] h10, h1, m10, m1, s10, s1;
   logic [1:0] mode;
   logic       blank_h, blank_m, day_tick;

   int vecCount = 0;
   int missCount = 0;
   bit checkEn = 1'b0;

   int tSec = 0;
   int mMode = 0;
   bit mTick = 1'b0;
   int mHour, mMin;

   clock_hms_counter dut (
      .clk      (clk),
      .reset    (reset),
      .sec_en   (sec_en),
      .blink    (blink),
      .mode_btn (mode_btn),
      .inc_btn  (inc_btn),
      .h10      (h10),
      .h1       (h1),
      .m10      (m10),
      .m1       (m1),
      .s10      (s10),
      .s1       (s1),
      .mode     (mode),
      .blank_h  (blank_h),
      .blank_m  (blank_m),
      .day_tick (day_tick)
   );

   always #10 clk = ~clk;

   // Reference model: time kept as seconds since midnight.
   always @(posedge clk) begin
      mTick = 1'b0;
      if (reset) begin
         tSec  = 0;
         mMode = 0;
      end else begin
         case (mMode)
            0: begin
               if (sec_en) begin
                  if (tSec == 86399) mTick = 1'b1;
                  tSec = (tSec + 1) % 86400;
               end
               if (mode_btn) mMode = 1;
            end
            1: begin
               if (mode_btn) mMode = 2;
               else if (inc_btn) begin
                  mHour = (tSec / 3600 + 1) % 24;
                  tSec  = mHour * 3600 + tSec % 3600;
               end
            end
            default: begin
               if (mode_btn) begin
                  mMode = 0;
                  tSec  = tSec - tSec % 60;
               end else if (inc_btn) begin
                  mMode = 2;
                  mMin  = ((tSec / 60) % 60 + 1) % 60;
                  tSec  = (tSec / 3600) * 3600 + mMin * 60 + tSec % 60;
               end
            end
         endcase
      end
   end

   // Every-cycle compare of all outputs against the model.
   always @(negedge clk) begin : cmpBlk
      logic [28:0] act, exp;
      int hh, mm, ss;
      if (checkEn) begin
         hh  = tSec / 3600;
         mm  = (tSec / 60) % 60;
         ss  = tSec % 60;
         act = {h10, h1, m10, m1, s10, s1, mode, blank_h, blank_m, day_tick};
         exp = {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                2'(mMode), 1'(mMode == 1 && !blink), 1'(mMode == 2 && !blink), mTick};
         vecCount++;
         if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL model-compare t=%0t got %h expected %h", $time, act, exp);
         end
      end
   end

   task automatic applyStimulus(input logic s, input logic m, input logic i);
      sec_en   = s;
      mode_btn = m;
      inc_btn  = i;
      @(posedge clk);
      #1;
      sec_en   = 1'b0;
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
   endtask

   task automatic repeatStimulus(input int n, input logic s, input logic m, input logic i);
      for (int k = 0; k < n; k++) applyStimulus(s, m, i);
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // From RUN at 00:00:00: enter set mode, step hours and minutes, return to RUN.
   task automatic setClock(input int incH, input int incM);
      applyStimulus(0, 1, 0);
      repeatStimulus(incH, 0, 0, 1);
      applyStimulus(0, 1, 0);
      repeatStimulus(incM, 0, 0, 1);
      applyStimulus(0, 1, 0);
   endtask

   task automatic checkOutput(input string name, input int hh, input int mm, input int ss,
                              input int md, input logic tk);
      logic [26:0] act, exp;
      act = {h10, h1, m10, m1, s10, s1, mode, day_tick};
      exp = {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
             2'(md), tk};
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkBlank(input string name, input logic eh, input logic em);
      vecCount++;
      if ({blank_h, blank_m} !== {eh, em}) begin
         missCount++;
         $display("[TB] FAIL %s blanks got %b%b expected %b%b", name, blank_h, blank_m, eh, em);
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      checkEn = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("reset", 0, 0, 0, 0, 1'b0);

      repeatStimulus(59, 1, 0, 0);
      checkOutput("sec59", 0, 0, 59, 0, 1'b0);
      applyStimulus(1, 0, 0);
      checkOutput("sec-carry", 0, 1, 0, 0, 1'b0);
      repeatStimulus(7, 1, 0, 0);
      checkOutput("sec7", 0, 1, 7, 0, 1'b0);

      applyStimulus(0, 1, 0);
      checkOutput("enter-set-hour", 0, 1, 7, 1, 1'b0);
      repeatStimulus(25, 0, 0, 1);
      checkOutput("hour-25-inc", 1, 1, 7, 1, 1'b0);
      repeatStimulus(3, 1, 0, 0);
      checkOutput("sec-frozen", 1, 1, 7, 1, 1'b0);
      applyStimulus(1, 0, 1);
      checkOutput("sec-and-inc", 2, 1, 7, 1, 1'b0);
      blink = 1'b1;
      applyStimulus(0, 0, 0);
      checkBlank("set-hour-blink1", 1'b0, 1'b0);
      blink = 1'b0;
      applyStimulus(0, 0, 0);
      checkBlank("set-hour-blink0", 1'b1, 1'b0);
      applyStimulus(0, 1, 0);
      checkOutput("enter-set-min", 2, 1, 7, 2, 1'b0);
      checkBlank("set-min-blink0", 1'b0, 1'b1);
      repeatStimulus(61, 0, 0, 1);
      checkOutput("min-61-inc", 2, 2, 7, 2, 1'b0);
      applyStimulus(0, 1, 0);
      checkOutput("exit-clears-sec", 2, 2, 0, 0, 1'b0);

      applyStimulus(0, 1, 0);
      applyStimulus(0, 1, 0);
      repeatStimulus(3, 0, 0, 1);
      checkOutput("mid-set-min", 2, 5, 0, 2, 1'b0);
      doReset();
      checkOutput("reset-mid-set", 0, 0, 0, 0, 1'b0);

      setClock(0, 59);
      repeatStimulus(59, 1, 0, 0);
      checkOutput("pre-00:59:59", 0, 59, 59, 0, 1'b0);
      applyStimulus(1, 0, 0);
      checkOutput("min-carry", 1, 0, 0, 0, 1'b0);

      doReset();
      setClock(9, 59);
      repeatStimulus(59, 1, 0, 0);
      applyStimulus(1, 0, 0);
      checkOutput("09-to-10", 10, 0, 0, 0, 1'b0);

      doReset();
      setClock(23, 59);
      repeatStimulus(59, 1, 0, 0);
      checkOutput("pre-23:59:59", 23, 59, 59, 0, 1'b0);
      applyStimulus(1, 0, 0);
      checkOutput("day-wrap", 0, 0, 0, 0, 1'b1);
      applyStimulus(0, 0, 0);
      checkOutput("day-tick-drop", 0, 0, 0, 0, 1'b0);

      applyStimulus(0, 1, 1);
      checkOutput("mode-and-inc", 0, 0, 0, 1, 1'b0);
      applyStimulus(0, 1, 0);
      applyStimulus(0, 1, 0);
      repeatStimulus(5, 1, 0, 0);
      applyStimulus(1, 1, 0);
      checkOutput("sec-and-mode", 0, 0, 6, 1, 1'b0);

      applyStimulus(0, 1, 0);
      applyStimulus(0, 1, 0);
      checkOutput("back-to-run", 0, 0, 0, 0, 1'b0);
      blink = 1'b1;
      applyStimulus(0, 0, 0);
      checkBlank("run-blink1", 1'b0, 1'b0);
      blink = 1'b0;
      applyStimulus(0, 0, 0);
      checkBlank("run-blink0", 1'b0, 1'b0);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
